// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-4 registered stream demultiplexer.
package demux_pkg;

    localparam int NOUT  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NOUT-1:0]  chmask_t;

    // Number of set bits in a channel mask (0..4).
    function automatic logic [2:0] popcount(chmask_t m);
        popcount = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/demux_route4_if.sv
// Producer-side and consumer-side signals of the 1-to-4 demultiplexer, bundled.
interface demux_route4_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    sel_t             sel;
    logic [WIDTH-1:0] inp;
    chmask_t          out_valid;
    chmask_t          out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    sel_t             last_sel;
    logic [CNT_W-1:0] delivered;

    modport master (
        output in_valid, sel, inp, out_ready,
        input  in_ready, out_valid, out0, out1, out2, out3, last_sel, delivered
    );

    modport slave (
        input  in_valid, sel, inp, out_ready,
        output in_ready, out_valid, out0, out1, out2, out3, last_sel, delivered
    );
endinterface

// File: rtl/demux_slot.sv
// One-entry output slot: a load always wins over a take, so a slot can be
// emptied and refilled in the same cycle.
module demux_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             take,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    // NOTE: state registers use non-blocking assignments so every slot samples
    // the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_route4.sv
// Registered 1-to-4 stream demultiplexer with per-channel backpressure and a
// running count of words taken by the consumers.
module demux_route4
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_route4_if.slave  bus
);

    chmask_t          valid;
    chmask_t          take;
    chmask_t          load;
    logic             ready;
    logic             acc;
    logic [WIDTH-1:0] data [NOUT];

    // Only the addressed slot gates acceptance; other full slots never block.
    assign ready = !valid[bus.sel] || bus.out_ready[bus.sel];
    assign acc   = bus.in_valid && ready;
    assign take  = valid & bus.out_ready;

    // NOTE: the default assignment first keeps this decode free of latches.
    always_comb begin
        load = '0;
        if (acc) begin
            load[bus.sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .take  (take[k]),
            .din   (bus.inp),
            .valid (valid[k]),
            .dout  (data[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.last_sel  <= '0;
            bus.delivered <= '0;
        end else begin
            if (acc) begin
                bus.last_sel <= bus.sel;
            end
            bus.delivered <= bus.delivered + CNT_W'(popcount(take));
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid;
    assign bus.out0      = data[0];
    assign bus.out1      = data[1];
    assign bus.out2      = data[2];
    assign bus.out3      = data[3];

endmodule

// File: doc/demux_route4.md
Name: demux_route4

Overview:
- Registered 1-to-4 stream demultiplexer: the steering counterpart of the 4:1 select path.
- Accepts one WIDTH-bit word per handshake on a single input channel.
- Steers each word by a 2-bit select into one of four one-entry output slots, each with its own valid/ready handshake.
- Sits between a single producer and four independent consumers; supplies per-channel backpressure and a running delivery count.

Parameters:
- WIDTH, 4, data width of input and of each output channel.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block accepts the word this cycle.
- sel  input  2  destination channel of the offered word (0..3).
- inp  input  WIDTH  offered data.
- out_valid  output  4  bit k: slot k holds a word.
- out_ready  input  4  bit k: consumer k takes slot k's word this cycle.
- out0, out1, out2, out3  output  WIDTH each  slot data.
- last_sel  output  2  channel of the most recently accepted word.
- delivered  output  CNT_W  count of words taken by consumers, wraps.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=4'b0000, out0..out3=0, last_sel=0, delivered=0. Takes effect immediately, independent of clk. Any in-flight words are discarded. No acceptance while rst_n is low.
- Accept: in_ready = !out_valid[sel] || out_ready[sel].
  - Purely combinational from current state and inputs.
  - Defined for every sel value 0..3.
  - in_ready does not depend on in_valid.
- Transfer in (acc) occurs when in_valid && in_ready.
  - Next edge: out<sel> <= inp, out_valid[sel] <= 1, last_sel <= sel.
- Transfer out on slot k: out_valid[k] && out_ready[k].
  - If no acc targets k in the same cycle, out_valid[k] <= 0 on the next edge.
  - out<k> holds its value; it is not cleared.
- Simultaneous take and load on the same slot: slot reloads with the new word and out_valid[k] stays 1. This gives full throughput of one word/cycle to a single channel when its consumer is always ready.
- Independence: transfers on different slots in the same cycle do not interact. Up to 4 takes plus 1 load per cycle.
- Latency: inp to out<sel>/out_valid is exactly 1 cycle.
- Full slot: if out_valid[sel]=1 and out_ready[sel]=0, then in_ready=0. The word is held upstream, and inp/sel must remain stable until accepted. Other full slots never block a word bound for a free slot (no head-of-line blocking beyond the offered word).
- Data stability: out<k> changes only on a load to slot k.
- delivered increments by the number of set bits in (out_valid & out_ready) each cycle (0..4). Modulo 2^CNT_W, wrapping 255 -> 0 for the default.
- last_sel updates only on acc.
- No combinational path from out_ready to out_valid or out<k>. The only combinational path is out_ready[sel]/sel/state -> in_ready.
- No latches: every combinational output is fully assigned for all select values.

Decomposition:
- Package demux_pkg holds:
  - NOUT=4
  - SEL_W=2
  - typedef logic[SEL_W-1:0] sel_t
  - typedef logic[NOUT-1:0] chmask_t
- Sub-module demux_slot (one-entry register with valid and load/take logic, parameter WIDTH), instantiated four times.
- Top-level contains the select decode, in_ready mux, last_sel and the popcount-add counter.

Test Plan:
1. Reset then single word: out_ready=4'b1111, offer sel=2, inp=4'hA for one cycle. -> in_ready=1; next cycle out_valid=4'b0100, out2=A, last_sel=2; following cycle out_valid=0, delivered=1.
2. Backpressure: out_ready[1]=0; send sel=1, inp=5, then offer sel=1, inp=6. -> second offer sees in_ready=0 and out1 stays 5. Raise out_ready[1]: that cycle in_ready=1, next edge out1=6 with out_valid[1] still 1.
3. No head-of-line blocking: slot 0 full and stalled; offer sel=3, inp=F. -> in_ready=1; out3=F next cycle; out0 unchanged.
4. Streaming: out_ready=4'b1111, in_valid held high for 8 cycles with sel cycling 0,1,2,3 and inp=1..8. -> in_ready=1 every cycle; each word appears 1 cycle later; delivered=8 after drain.
5. Counter wrap and multi-take: preload all four slots with ready low, then raise out_ready=4'b1111 for one cycle with delivered=254. -> delivered=2 (254+4 mod 256); out_valid=0.
6. Async reset mid-operation: slots 0 and 2 full; pull rst_n low between clock edges. -> out_valid=0, out0..out3=0, delivered=0 immediately. After release, first accepted word behaves as in scenario 1.
